// File: rtl/spi_ram_pkg.sv
// Shared command encodings and the pointer wrap helper for the SPI burst RAM.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Next burst address: the last word wraps back to 0, never beyond depth-1.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port RAM: synchronous write, registered read-first output, no reset.
module ram_sp_sync #(
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_SIZE-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Write and read share one port; a read sees the word held before this edge.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI command-frame decoder over a single-port RAM with independent write/read
// burst pointers and a tx_valid/tx_ready return path.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter  int MEM_DEPTH  = 256,
  parameter  int ADDR_SIZE  = 8,
  parameter  int DATA_WIDTH = 8,
  localparam int PAY_W      = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [PAY_W+1:0]      din,
  input  logic                  auto_inc,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  cmd_err
);

  logic [1:0]            cmd;
  logic [PAY_W-1:0]      payload;
  logic [ADDR_SIZE-1:0]  wr_ptr, rd_ptr, ram_addr;
  logic                  wr_ok, rd_ok, busy;
  logic                  wr_go, rd_go, err_d;
  logic [DATA_WIDTH-1:0] ram_q, hold_q;
  logic                  fresh;

  assign cmd     = din[PAY_W+1:PAY_W];
  assign payload = din[PAY_W-1:0];

  // Pointers may legally hold values past the array; such accesses are rejected.
  assign wr_ok = 32'(wr_ptr) < MEM_DEPTH;
  assign rd_ok = 32'(rd_ptr) < MEM_DEPTH;
  assign busy  = tx_valid && !tx_ready;

  assign wr_go = rx_valid && (cmd == CMD_WR_DATA) && wr_ok;
  assign rd_go = rx_valid && (cmd == CMD_RD_DATA) && rd_ok && !busy;
  assign err_d = rx_valid && (((cmd == CMD_WR_DATA) && !wr_ok) ||
                              ((cmd == CMD_RD_DATA) && (!rd_ok || busy)));

  // Only one command per cycle, so the port is never asked to read and write at once.
  assign ram_addr = rd_go ? rd_ptr : wr_ptr;

  ram_sp_sync #(
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_SIZE  (ADDR_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_go),
    .re    (rd_go),
    .addr  (ram_addr),
    .wdata (payload[DATA_WIDTH-1:0]),
    .rdata (ram_q)
  );

  // The RAM output has no reset, so dout shows it only on the cycle after a read
  // and otherwise replays the resettable holding copy.
  assign dout = fresh ? ram_q : hold_q;

  // Decode state: pointers, valid flag, error pulse and the dout holding copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
      fresh    <= 1'b0;
      hold_q   <= '0;
    end else begin
      cmd_err <= err_d;
      fresh   <= rd_go;
      hold_q  <= dout;

      if (rd_go)                    tx_valid <= 1'b1;
      else if (tx_valid && tx_ready) tx_valid <= 1'b0;

      if (rx_valid && (cmd == CMD_WR_ADDR))
        wr_ptr <= payload[ADDR_SIZE-1:0];
      else if (wr_go && auto_inc)
        wr_ptr <= ADDR_SIZE'(ptr_next(int'(wr_ptr), MEM_DEPTH));

      if (rx_valid && (cmd == CMD_RD_ADDR))
        rd_ptr <= payload[ADDR_SIZE-1:0];
      else if (rd_go && auto_inc)
        rd_ptr <= ADDR_SIZE'(ptr_next(int'(rd_ptr), MEM_DEPTH));
    end
  end

endmodule
